// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt datapath: the inverse S-box table,
// the InvSubBytes FSM state encoding and the word width.
package aes_pkg;

    localparam int AES_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } inv_sub_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox_word.sv
// Combinational inverse S-box over one 32-bit word: four independent byte
// lookups, byte positions preserved.
module aes_inv_sbox_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] in,
    output logic [AES_WORD_W-1:0] out
);

    for (genvar b = 0; b < AES_WORD_W / 8; b++) begin : g_byte
        assign out[b*8 +: 8] = INV_SBOX[in[b*8 +: 8]];
    end

endmodule

// File: rtl/aes_inv_sbox_128_iter.sv
// Iterative 128-bit InvSubBytes: WPC words are substituted per cycle in place,
// and the finished state is held with valid until the consumer takes it.
module aes_inv_sbox_128_iter
    import aes_pkg::*;
#(
    parameter int WPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NWORDS = 4;
    localparam int NCYC   = (WPC > 0) ? NWORDS / WPC : 1;
    localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (WPC != 1 && WPC != 2 && WPC != 4) begin : g_bad_wpc
        $error("aes_inv_sbox_128_iter: WPC must be 1, 2 or 4 (got %0d)", WPC);
    end

    inv_sub_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [127:0]          data_q, data_d;
    logic [127:0]          window;
    logic [127:0]          merged;
    logic [AES_WORD_W-1:0] sub_in  [WPC];
    logic [AES_WORD_W-1:0] sub_out [WPC];
    logic                  accept;

    // Shift the current group of words down to word 0 so the S-box lanes see fixed slices.
    assign window = data_q >> (AES_WORD_W * WPC * int'(cnt_q));

    for (genvar w = 0; w < WPC; w++) begin : g_lane
        assign sub_in[w] = window[w*AES_WORD_W +: AES_WORD_W];
        aes_inv_sbox_word u_word (
            .in  (sub_in[w]),
            .out (sub_out[w])
        );
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_merge
        assign merged[k*AES_WORD_W +: AES_WORD_W] =
            (k / WPC == int'(cnt_q)) ? sub_out[k % WPC] : data_q[k*AES_WORD_W +: AES_WORD_W];
    end

    assign in_ready  = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                data_d = merged;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the data register is reset too, since out_data must read zero after reset.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_sbox_128_iter.sv
// Self-checking bench: WPC=1,2,4 instances checked against an inverse S-box
// derived from GF(2^8) arithmetic and the AES affine map.
`timescale 1ns/1ps
module tb_aes_inv_sbox_128_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_data  [3];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_sbox_128_iter #(.WPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] binv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            binv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) binv = 8'(y);
            s = binv ^ {binv[6:0], binv[7]} ^ {binv[5:0], binv[7:6]} ^
                {binv[4:0], binv[7:5]} ^ {binv[3:0], binv[7:4]} ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[d[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers d, waits (bounded) for acceptance and then for out_valid; lat counts edges after accept.
    task automatic send(input int idx, input logic [127:0] d, output logic [127:0] got,
                        output int lat, output bit ok);
        in_data[idx]  = d;
        in_valid[idx] = 1'b1;
        for (int c = 0; c < 20 && in_ready[idx] !== 1'b1; c++) tick();
        ok  = (in_ready[idx] === 1'b1);
        lat = 0;
        got = '0;
        if (ok) begin
            tick();
            in_valid[idx] = 1'b0;
            in_data[idx]  = rand128();
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                tick();
                lat++;
                ok = (out_valid[idx] === 1'b1);
            end
            got = out_data[idx];
        end
        in_valid[idx] = 1'b0;
    endtask

    task automatic test_reset(input int idx);
        int  wpc = 1 << idx;
        bit  stale;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = rand128();
        end
        tick();
        tick();
        tests_run++;
        if (in_ready[idx] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_low wpc=%0d got=%b exp=0", wpc, in_ready[idx]);
        end
        tests_run++;
        if (out_valid[idx] !== 1'b0 || out_data[idx] !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs wpc=%0d got=%b/%h exp=0/0", wpc, out_valid[idx], out_data[idx]);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready[idx] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready wpc=%0d got=%b exp=1", wpc, in_ready[idx]);
        end
        // Accept a state, then reset one cycle later while it is mid-transform.
        in_data[idx]  = rand128();
        in_valid[idx] = 1'b1;
        tick();
        in_valid[idx] = 1'b0;
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (out_valid[idx] !== 1'b0 || out_data[idx] !== 128'h0 || in_ready[idx] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_busy wpc=%0d got=%b/%h/%b exp=0/0/0",
                     wpc, out_valid[idx], out_data[idx], in_ready[idx]);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready[idx] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_busy_ready wpc=%0d got=%b exp=1", wpc, in_ready[idx]);
        end
        out_ready[idx] = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid[idx] !== 1'b0) stale = 1'b1;
        end
        tests_run++;
        if (stale) begin
            tests_failed++;
            $display("FAIL reset_no_stale wpc=%0d got=1 exp=0", wpc);
        end
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_known(input int idx);
        int           wpc  = 1 << idx;
        int           ncyc = 4 >> idx;
        logic [127:0] got;
        int           lat;
        bit           ok;
        out_ready[idx] = 1'b1;
        send(idx, 128'h637c777bf26b6fc53001672bfed7ab76, got, lat, ok);
        tests_run++;
        if (!ok || lat != ncyc) begin
            tests_failed++;
            $display("FAIL known_latency wpc=%0d got=%0d exp=%0d (ok=%0b)", wpc, lat, ncyc, ok);
        end
        tests_run++;
        if (got !== 128'h000102030405060708090a0b0c0d0e0f) begin
            tests_failed++;
            $display("FAIL known_vector wpc=%0d got=%h exp=000102030405060708090a0b0c0d0e0f", wpc, got);
        end
        tick();
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_const(input int idx);
        int           wpc = 1 << idx;
        logic [7:0]   in_b  [3] = '{8'h00, 8'h16, 8'hed};
        logic [7:0]   exp_b [3] = '{8'h52, 8'hff, 8'h53};
        logic [127:0] got;
        int           lat;
        bit           ok;
        out_ready[idx] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(idx, {16{in_b[i]}}, got, lat, ok);
            tests_run++;
            if (!ok || got !== {16{exp_b[i]}}) begin
                tests_failed++;
                $display("FAIL const_%h wpc=%0d got=%h exp=%h", in_b[i], wpc, got, {16{exp_b[i]}});
            end
            tick();
        end
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_random(input int idx);
        int           wpc = 1 << idx;
        logic [127:0] d;
        logic [127:0] got;
        int           lat;
        int           stall;
        bit           ok;
        bit           held;
        for (int i = 0; i < 16; i++) begin
            d = rand128();
            stall = $urandom_range(0, 3);
            out_ready[idx] = 1'b0;
            send(idx, d, got, lat, ok);
            held = ok;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (out_valid[idx] !== 1'b1 || out_data[idx] !== got) held = 1'b0;
            end
            out_ready[idx] = 1'b1;
            tick();
            out_ready[idx] = 1'b0;
            tests_run++;
            if (!held || got !== model_inv(d)) begin
                tests_failed++;
                $display("FAIL random_%0d wpc=%0d got=%h exp=%h", i, wpc, got, model_inv(d));
            end
        end
    endtask

    task automatic test_backpressure(input int idx);
        int           wpc = 1 << idx;
        logic [127:0] d = rand128();
        logic [127:0] got;
        int           lat;
        bit           ok;
        bit           extra;
        out_ready[idx] = 1'b0;
        send(idx, d, got, lat, ok);
        tests_run++;
        if (!ok || got !== model_inv(d)) begin
            tests_failed++;
            $display("FAIL bp_result wpc=%0d got=%h exp=%h", wpc, got, model_inv(d));
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if (out_valid[idx] !== 1'b1 || out_data[idx] !== model_inv(d) || in_ready[idx] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d wpc=%0d got=%b/%h/%b exp=1/%h/0",
                         c, wpc, out_valid[idx], out_data[idx], in_ready[idx], model_inv(d));
            end
        end
        out_ready[idx] = 1'b1;
        #1;
        tests_run++;
        if (in_ready[idx] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ready_follows wpc=%0d got=%b exp=1", wpc, in_ready[idx]);
        end
        tick();
        extra = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid[idx] !== 1'b0) extra = 1'b1;
            tick();
        end
        tests_run++;
        if (extra) begin
            tests_failed++;
            $display("FAIL bp_single_transfer wpc=%0d got=repeat exp=one", wpc);
        end
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_back_to_back(input int idx);
        int           wpc  = 1 << idx;
        int           ncyc = 4 >> idx;
        logic [127:0] src [3];
        logic [127:0] rd  [3];
        int           rc  [3];
        int           sent = 0;
        int           rcvd = 0;
        bit           extra = 1'b0;
        for (int i = 0; i < 3; i++) src[i] = rand128();
        out_ready[idx] = 1'b1;
        for (int c = 0; c < 80 && rcvd < 3; c++) begin
            in_valid[idx] = (sent < 3);
            in_data[idx]  = src[(sent < 3) ? sent : 0];
            #1;
            if (out_valid[idx] === 1'b1) begin
                rd[rcvd] = out_data[idx];
                rc[rcvd] = c;
                rcvd++;
            end
            if (in_valid[idx] && in_ready[idx] === 1'b1) sent++;
            tick();
        end
        in_valid[idx] = 1'b0;
        for (int c = 0; c < ncyc + 3; c++) begin
            if (out_valid[idx] !== 1'b0) extra = 1'b1;
            tick();
        end
        tests_run++;
        if (rcvd != 3 || sent != 3 || extra) begin
            tests_failed++;
            $display("FAIL b2b_count wpc=%0d got=%0d sent=%0d extra=%0b exp=3/3/0", wpc, rcvd, sent, extra);
        end
        for (int i = 0; i < rcvd; i++) begin
            tests_run++;
            if (rd[i] !== model_inv(src[i])) begin
                tests_failed++;
                $display("FAIL b2b_data_%0d wpc=%0d got=%h exp=%h", i, wpc, rd[i], model_inv(src[i]));
            end
        end
        for (int i = 1; i < rcvd; i++) begin
            tests_run++;
            if (rc[i] - rc[i-1] != ncyc + 1) begin
                tests_failed++;
                $display("FAIL b2b_spacing_%0d wpc=%0d got=%0d exp=%0d", i, wpc, rc[i] - rc[i-1], ncyc + 1);
            end
        end
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_sweep(input int idx);
        int           wpc = 1 << idx;
        logic [127:0] got;
        int           lat;
        bit           ok;
        bit           round_trip;
        out_ready[idx] = 1'b1;
        for (int b = 0; b < 256; b++) begin
            send(idx, {16{8'(b)}}, got, lat, ok);
            tests_run++;
            if (!ok || got !== {16{inv_tab[b]}}) begin
                tests_failed++;
                $display("FAIL sweep_%02h wpc=%0d got=%h exp=%h", b, wpc, got, {16{inv_tab[b]}});
            end
            round_trip = ok;
            for (int l = 0; l < 16; l++)
                if (fwd_tab[got[l*8 +: 8]] != 8'(b)) round_trip = 1'b0;
            tests_run++;
            if (!round_trip) begin
                tests_failed++;
                $display("FAIL sweep_roundtrip_%02h wpc=%0d got=%h exp=%h", b, wpc, got, {16{8'(b)}});
            end
            tick();
        end
        out_ready[idx] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end
        build_tables();
        for (int idx = 0; idx < 3; idx++) begin
            test_reset(idx);
            test_known(idx);
            test_const(idx);
            test_random(idx);
            test_backpressure(idx);
            test_back_to_back(idx);
            test_sweep(idx);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
